// File: rtl/fabric_jtag_tap_pkg.sv
// fabric_jtag_tap_pkg: TAP state encoding (IEEE 1149.1 style) and opcode constants.
package fabric_jtag_tap_pkg;
  typedef enum logic [3:0] {
    S_EXIT2_DR   = 4'h0,
    S_EXIT1_DR   = 4'h1,
    S_SHIFT_DR   = 4'h2,
    S_PAUSE_DR   = 4'h3,
    S_SELECT_IR  = 4'h4,
    S_UPDATE_DR  = 4'h5,
    S_CAPTURE_DR = 4'h6,
    S_SELECT_DR  = 4'h7,
    S_EXIT2_IR   = 4'h8,
    S_EXIT1_IR   = 4'h9,
    S_SHIFT_IR   = 4'hA,
    S_PAUSE_IR   = 4'hB,
    S_RTI        = 4'hC,
    S_UPDATE_IR  = 4'hD,
    S_CAPTURE_IR = 4'hE,
    S_TLR        = 4'hF
  } tap_state_t;
  // Opcodes; BYPASS is all-ones at any IR width once cast.
  localparam int OPC_BYPASS = -1;
  localparam int OPC_IDCODE = 1;
endpackage

// File: rtl/fabric_jtag_tap_fsm.sv
// fabric_jtag_tap_fsm: 16-state TAP controller.
//   clk, rst_n (async, active-low), tms in; state plus capture/shift/update/tlr strobes out.
module fabric_jtag_tap_fsm
  import fabric_jtag_tap_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tms,
  output tap_state_t state,
  output logic       tlr,
  output logic       capture_ir,
  output logic       shift_ir,
  output logic       update_ir,
  output logic       capture_dr,
  output logic       shift_dr,
  output logic       update_dr
);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= S_TLR;
    else
      case (state)
        S_TLR:        state <= tms ? S_TLR       : S_RTI;
        S_RTI:        state <= tms ? S_SELECT_DR : S_RTI;
        S_SELECT_DR:  state <= tms ? S_SELECT_IR : S_CAPTURE_DR;
        S_CAPTURE_DR: state <= tms ? S_EXIT1_DR  : S_SHIFT_DR;
        S_SHIFT_DR:   state <= tms ? S_EXIT1_DR  : S_SHIFT_DR;
        S_EXIT1_DR:   state <= tms ? S_UPDATE_DR : S_PAUSE_DR;
        S_PAUSE_DR:   state <= tms ? S_EXIT2_DR  : S_PAUSE_DR;
        S_EXIT2_DR:   state <= tms ? S_UPDATE_DR : S_SHIFT_DR;
        S_UPDATE_DR:  state <= tms ? S_SELECT_DR : S_RTI;
        S_SELECT_IR:  state <= tms ? S_TLR       : S_CAPTURE_IR;
        S_CAPTURE_IR: state <= tms ? S_EXIT1_IR  : S_SHIFT_IR;
        S_SHIFT_IR:   state <= tms ? S_EXIT1_IR  : S_SHIFT_IR;
        S_EXIT1_IR:   state <= tms ? S_UPDATE_IR : S_PAUSE_IR;
        S_PAUSE_IR:   state <= tms ? S_EXIT2_IR  : S_PAUSE_IR;
        S_EXIT2_IR:   state <= tms ? S_UPDATE_IR : S_SHIFT_IR;
        S_UPDATE_IR:  state <= tms ? S_SELECT_DR : S_RTI;
        default:      state <= S_TLR;
      endcase
  assign tlr        = state == S_TLR;
  assign capture_ir = state == S_CAPTURE_IR;
  assign shift_ir   = state == S_SHIFT_IR;
  assign update_ir  = state == S_UPDATE_IR;
  assign capture_dr = state == S_CAPTURE_DR;
  assign shift_dr   = state == S_SHIFT_DR;
  assign update_dr  = state == S_UPDATE_DR;
endmodule

// File: rtl/fabric_jtag_tap.sv
// fabric_jtag_tap: fabric-side JTAG TAP slave with IR, BYPASS, optional IDCODE and a USER DR.
//   JTAG_TCK/JTAG_TRSTN clock and async active-low reset; JTAG_TDI/JTAG_TMS in; JTAG_TDO/JTAG_TDO_EN out (TCK fall);
//   USER_CAPTURE_DATA in, USER_UPDATE_DATA/USER_UPDATE_VALID out; TAP_STATE and IR_VALUE debug out.
//   Define FABRIC_JTAG_TAP_IDCODE_EN to decode IDCODE (opcode 1) and make it the reset instruction.
module fabric_jtag_tap
  import fabric_jtag_tap_pkg::*;
#(
  parameter int                     IR_WIDTH     = 4,
  parameter int                     DR_WIDTH     = 32,
  parameter logic [31:0]            IDCODE_VALUE = 32'h1A5B_C001,
  parameter logic [IR_WIDTH-1:0]    USER_OPCODE  = IR_WIDTH'(8)
) (
  input  logic                JTAG_TCK,
  input  logic                JTAG_TRSTN,
  input  logic                JTAG_TDI,
  input  logic                JTAG_TMS,
  output logic                JTAG_TDO,
  output logic                JTAG_TDO_EN,
  input  logic [DR_WIDTH-1:0] USER_CAPTURE_DATA,
  output logic [DR_WIDTH-1:0] USER_UPDATE_DATA,
  output logic                USER_UPDATE_VALID,
  output logic [3:0]          TAP_STATE,
  output logic [IR_WIDTH-1:0] IR_VALUE
);
`ifdef FABRIC_JTAG_TAP_IDCODE_EN
  localparam logic [IR_WIDTH-1:0] IR_RESET = IR_WIDTH'(OPC_IDCODE);
`else
  localparam logic [IR_WIDTH-1:0] IR_RESET = IR_WIDTH'(OPC_BYPASS);
`endif
  tap_state_t state;
  logic tlr, capture_ir, shift_ir, update_ir, capture_dr, shift_dr, update_dr;
  logic [IR_WIDTH-1:0] ir, ir_sr;
  logic [DR_WIDTH-1:0] user_sr;
  logic [31:0] id_sr;
  logic bypass_sr, sel_user, sel_id, dr_lsb;
  fabric_jtag_tap_fsm u_fsm (
    .clk        (JTAG_TCK),
    .rst_n      (JTAG_TRSTN),
    .tms        (JTAG_TMS),
    .state      (state),
    .tlr        (tlr),
    .capture_ir (capture_ir),
    .shift_ir   (shift_ir),
    .update_ir  (update_ir),
    .capture_dr (capture_dr),
    .shift_dr   (shift_dr),
    .update_dr  (update_dr)
  );
  assign sel_user = ir == USER_OPCODE;
`ifdef FABRIC_JTAG_TAP_IDCODE_EN
  assign sel_id = ir == IR_WIDTH'(OPC_IDCODE) && !sel_user;
`else
  assign sel_id = 1'b0;
`endif
  assign dr_lsb    = sel_user ? user_sr[0] : sel_id ? id_sr[0] : bypass_sr;
  assign TAP_STATE = state;
  assign IR_VALUE  = ir;
  // Shifts are written as a widened right shift so a 1-bit DR needs no special case.
  always_ff @(posedge JTAG_TCK or negedge JTAG_TRSTN)
    if (!JTAG_TRSTN) begin
      ir                <= IR_RESET;
      ir_sr             <= '0;
      user_sr           <= '0;
      id_sr             <= '0;
      bypass_sr         <= 1'b0;
      USER_UPDATE_DATA  <= '0;
      USER_UPDATE_VALID <= 1'b0;
    end else begin
      ir                <= tlr ? IR_RESET : update_ir ? ir_sr : ir;
      ir_sr             <= capture_ir ? IR_WIDTH'(2'b01) :
                           shift_ir ? IR_WIDTH'({JTAG_TDI, ir_sr} >> 1) : ir_sr;
      bypass_sr         <= capture_dr ? 1'b0 : shift_dr ? JTAG_TDI : bypass_sr;
      id_sr             <= capture_dr && sel_id ? IDCODE_VALUE :
                           shift_dr && sel_id ? 32'({JTAG_TDI, id_sr} >> 1) : id_sr;
      user_sr           <= capture_dr && sel_user ? USER_CAPTURE_DATA :
                           shift_dr && sel_user ? DR_WIDTH'({JTAG_TDI, user_sr} >> 1) : user_sr;
      USER_UPDATE_DATA  <= update_dr && sel_user ? user_sr : USER_UPDATE_DATA;
      USER_UPDATE_VALID <= update_dr && sel_user;
    end
  always_ff @(negedge JTAG_TCK or negedge JTAG_TRSTN)
    if (!JTAG_TRSTN) begin
      JTAG_TDO    <= 1'b0;
      JTAG_TDO_EN <= 1'b0;
    end else begin
      JTAG_TDO    <= shift_ir ? ir_sr[0] : shift_dr ? dr_lsb : 1'b0;
      JTAG_TDO_EN <= shift_ir || shift_dr;
    end
endmodule

// File: tb/tb_fabric_jtag_tap.sv
// tb_fabric_jtag_tap: scoreboard bench for fabric_jtag_tap (TDO stream and USER update queues).
module tb_fabric_jtag_tap;
  import fabric_jtag_tap_pkg::*;
  logic        tck = 1'b0, trstn = 1'b0, tdi = 1'b0, tms = 1'b1;
  logic [31:0] cap = '0;
  logic        tdo, tdo_en, valid;
  logic [31:0] upd;
  logic [3:0]  tap_state, ir;
  int          n_chk = 0, n_fail = 0;
  logic        tdo_q[$];
  logic [31:0] upd_q[$];
  logic        exp_bit;
  logic [31:0] exp_upd;
`ifdef FABRIC_JTAG_TAP_IDCODE_EN
  localparam logic [3:0] IR_RST = 4'h1;
`else
  localparam logic [3:0] IR_RST = 4'hF;
`endif
  fabric_jtag_tap dut (
    .JTAG_TCK          (tck),
    .JTAG_TRSTN        (trstn),
    .JTAG_TDI          (tdi),
    .JTAG_TMS          (tms),
    .JTAG_TDO          (tdo),
    .JTAG_TDO_EN       (tdo_en),
    .USER_CAPTURE_DATA (cap),
    .USER_UPDATE_DATA  (upd),
    .USER_UPDATE_VALID (valid),
    .TAP_STATE         (tap_state),
    .IR_VALUE          (ir)
  );
  always #10 tck = ~tck;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic tick(input logic m, input logic d);
    @(negedge tck);
    #2 tms = m;
    tdi = d;
    @(posedge tck);
    #1;
  endtask
  task automatic push_bits(input logic [31:0] v, input int n);
    for (int i = 0; i < n; i++) tdo_q.push_back(v[i]);
  endtask
  task automatic pulse_reset();
    @(negedge tck);
    #2 trstn = 1'b0;
    #4 trstn = 1'b1;
  endtask
  task automatic shift_ir(input logic [3:0] v);
    tick(1, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    push_bits(32'h1, 4);
    for (int i = 0; i < 4; i++) tick(i == 3, v[i]);
    tick(1, 0); tick(0, 0);
  endtask
  task automatic shift_dr(input logic [31:0] v, input int n, input logic [31:0] exp, input int pause_at);
    tick(1, 0); tick(0, 0); tick(0, 0);
    push_bits(exp, n);
    for (int i = 0; i < n; i++) begin
      tick(i == n - 1 || i == pause_at - 1, v[i]);
      if (i == pause_at - 1 && i != n - 1) begin
        tick(0, 0); tick(0, 0); tick(1, 0); tick(0, 0);
      end
    end
    tick(1, 0); tick(0, 0);
  endtask
  always @(negedge tck) begin
    #3;
    if (tdo_en) begin
      n_chk++;
      if (tdo_q.size() == 0) begin
        n_fail++;
        $display("FAIL tdo_unexpected: got tdo=%b with tdo_en=1, expected no shift", tdo);
      end else begin
        exp_bit = tdo_q.pop_front();
        if (tdo !== exp_bit) begin
          n_fail++;
          $display("FAIL tdo_bit: got %b expected %b", tdo, exp_bit);
        end
      end
    end
  end
  always @(posedge tck) begin
    #1;
    if (valid) begin
      n_chk++;
      if (upd_q.size() == 0) begin
        n_fail++;
        $display("FAIL valid_unexpected: got valid=1 data=%h, expected valid=0", upd);
      end else begin
        exp_upd = upd_q.pop_front();
        if (upd !== exp_upd) begin
          n_fail++;
          $display("FAIL update_data: got %h expected %h", upd, exp_upd);
        end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end
  initial begin
    pulse_reset();
    chk("reset_state", 32'(tap_state), 32'(S_TLR));
    chk("reset_tdo_en", 32'(tdo_en), 0);
    chk("reset_tdo", 32'(tdo), 0);
    chk("reset_ir", 32'(ir), 32'(IR_RST));
    chk("reset_upd", upd, 0);
    chk("reset_valid", 32'(valid), 0);
    tick(0, 0); tick(1, 0); tick(0, 0); tick(0, 0);
    chk("in_shift_dr", 32'(tap_state), 32'(S_SHIFT_DR));
`ifdef FABRIC_JTAG_TAP_IDCODE_EN
    push_bits(32'h1, 1);
`else
    push_bits(32'h0, 1);
`endif
    repeat (5) tick(1, 0);
    chk("tms5_state", 32'(tap_state), 32'(S_TLR));
    chk("tms5_tdo_en", 32'(tdo_en), 0);
    chk("tms5_ir", 32'(ir), 32'(IR_RST));
    tick(0, 0);
    chk("rti_state", 32'(tap_state), 32'(S_RTI));
`ifdef FABRIC_JTAG_TAP_IDCODE_EN
    shift_dr(32'h0, 32, 32'h1A5B_C001, 0);
`else
    shift_dr(32'h03C, 9, 32'h078, 0);
`endif
    shift_ir(4'hF);
    chk("ir_bypass", 32'(ir), 32'hF);
    shift_dr(32'h0A5, 9, 32'h14A, 0);
    cap = 32'h1234_5678;
    shift_ir(4'h8);
    chk("ir_user", 32'(ir), 32'h8);
    upd_q.push_back(32'hDEAD_BEEF);
    shift_dr(32'hDEAD_BEEF, 32, 32'h1234_5678, 16);
    chk("user_valid_hi", 32'(valid), 1);
    chk("user_upd", upd, 32'hDEAD_BEEF);
    tick(0, 0);
    chk("user_valid_lo", 32'(valid), 0);
    chk("user_upd_hold", upd, 32'hDEAD_BEEF);
    cap = 32'hCAFE_F00D;
    tick(1, 0); tick(0, 0); tick(0, 0);
    push_bits(cap, 10);
    for (int i = 0; i < 10; i++) tick(0, i[0]);
    pulse_reset();
    chk("abort_state", 32'(tap_state), 32'(S_TLR));
    chk("abort_valid", 32'(valid), 0);
    chk("abort_upd", upd, 0);
    chk("abort_ir", 32'(ir), 32'(IR_RST));
    chk("abort_tdo_en", 32'(tdo_en), 0);
    repeat (3) tick(1, 0);
    repeat (3) tick(0, 0);
    chk("abort_valid_after", 32'(valid), 0);
    chk("tdo_q_empty", tdo_q.size(), 0);
    chk("upd_q_empty", upd_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
